// File: rtl/lcd_timing_pkg.sv
// Shared types and 800x480 default timing for the LCD RGB timing generator.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } lcd_state_e;

  // Counter width covers totals up to 4095 clocks/lines.
  localparam int unsigned CNT_W = 12;

  localparam int unsigned DEF_H_SYNC  = 128;
  localparam int unsigned DEF_H_BACK  = 88;
  localparam int unsigned DEF_H_DISP  = 800;
  localparam int unsigned DEF_H_FRONT = 40;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BACK  = 33;
  localparam int unsigned DEF_V_DISP  = 480;
  localparam int unsigned DEF_V_FRONT = 10;

  function automatic int unsigned lcd_total(input int unsigned sync_w,
                                            input int unsigned back_w,
                                            input int unsigned disp_w,
                                            input int unsigned front_w);
    return sync_w + back_w + disp_w + front_w;
  endfunction

endpackage

// File: rtl/lcd_sync_cnt.sv
// Horizontal/vertical position counter pair; exposes next-cycle position so
// the top can register its outputs in step with the counters.
module lcd_sync_cnt
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = 1056,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  output logic [CNT_W-1:0] h_nxt_o,
  output logic [CNT_W-1:0] v_nxt_o,
  output logic             frame_end_o
);

  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_last, v_last;

  assign h_last      = (h_q == H_MAX);
  assign v_last      = (v_q == V_MAX);
  assign frame_end_o = run_i & h_last & v_last;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_nxt_o = h_d;
  assign v_nxt_o = v_d;

endmodule

// File: rtl/lcd_rgb_timing.sv
// RGB parallel LCD timing generator: syncs, data enable, lead-time pixel
// requests and a registered pixel path, with graceful end-of-frame stop.
module lcd_rgb_timing
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_DISP   = DEF_H_DISP,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_DISP   = DEF_V_DISP,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned RGB_W    = 24,
  parameter int unsigned REQ_LEAD = 2,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [RGB_W-1:0] pixel_data,
  output logic             data_req,
  output logic [10:0]      pixel_x,
  output logic [10:0]      pixel_y,
  output logic             lcd_de,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic [RGB_W-1:0] lcd_rgb,
  output logic             lcd_bl,
  output logic             frame_start,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  localparam int unsigned H_TOTAL = lcd_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int unsigned V_TOTAL = lcd_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] H_REQ_S  = CNT_W'(H_SYNC + H_BACK - REQ_LEAD);
  localparam logic [CNT_W-1:0] H_REQ_E  = CNT_W'(H_SYNC + H_BACK + H_DISP - REQ_LEAD);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BACK + V_DISP);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             frame_end;
  logic             run_q, run_d;

  logic             de_d, req_d, hs_d, vs_d, fs_d;
  logic [10:0]      px_d, py_d;
  logic [RGB_W-1:0] rgb_d;
  logic             h_act, v_act, h_req;

  logic             de_q, req_q, hs_q, vs_q, fs_q, bl_q;
  logic [10:0]      px_q, py_q;
  logic [RGB_W-1:0] rgb_q;
  logic [15:0]      frame_cnt_q;

  assign run_q = (state_q != ST_IDLE);

  lcd_sync_cnt #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_cnt (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .run_i      (run_q),
    .h_nxt_o    (h_nxt),
    .v_nxt_o    (v_nxt),
    .frame_end_o(frame_end)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // STOP keeps counting so the current frame always finishes before IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_STOP;
      ST_STOP: begin
        if (en)             state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next position so the registered outputs
  // line up with the counter values of the same cycle.
  always_comb begin
    run_d = (state_d != ST_IDLE);
    h_act = (h_nxt >= H_ACT_S) && (h_nxt < H_ACT_E);
    v_act = (v_nxt >= V_ACT_S) && (v_nxt < V_ACT_E);
    h_req = (h_nxt >= H_REQ_S) && (h_nxt < H_REQ_E);
    de_d  = run_d && h_act && v_act;
    req_d = run_d && h_req && v_act;
    hs_d  = (run_d && (h_nxt < H_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (run_d && (v_nxt < V_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
    fs_d  = run_d && (h_nxt == '0) && (v_nxt == '0);
    px_d  = req_d ? 11'(h_nxt - H_REQ_S) : '0;
    py_d  = req_d ? 11'(v_nxt - V_ACT_S) : '0;
    rgb_d = de_d ? pixel_data : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_q        <= 1'b0;
      req_q       <= 1'b0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      fs_q        <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      rgb_q       <= '0;
      bl_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      de_q  <= de_d;
      req_q <= req_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
      px_q  <= px_d;
      py_q  <= py_d;
      rgb_q <= rgb_d;
      bl_q  <= 1'b1;
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign lcd_de      = de_q;
  assign data_req    = req_q;
  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign frame_start = fs_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign lcd_rgb     = rgb_q;
  assign lcd_bl      = bl_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = run_q;

endmodule

// File: tb/tb_lcd_rgb_timing.sv
// Directed bench for lcd_rgb_timing on a 10x6 miniature frame.
module tb_lcd_rgb_timing;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] pixel_data;
  logic        data_req;
  logic [10:0] pixel_x, pixel_y;
  logic        lcd_de, lcd_hs, lcd_vs, lcd_bl, frame_start, busy;
  logic [23:0] lcd_rgb;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  lcd_rgb_timing #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
    .RGB_W(24), .REQ_LEAD(2), .SYNC_POL(1'b0)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .en         (en),
    .pixel_data (pixel_data),
    .data_req   (data_req),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .lcd_de     (lcd_de),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_rgb    (lcd_rgb),
    .lcd_bl     (lcd_bl),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] enc(input int y, input int x);
    logic [23:0] r;
    r       = 24'h5A0000;
    r[15:8] = y[7:0];
    r[7:0]  = x[7:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel source: answers each request one clock later; junk otherwise.
  logic        pend_vld = 1'b0;
  logic [23:0] pend = '0;
  initial begin
    pixel_data = 24'hFFFFFF;
    forever begin
      @(negedge clk);
      pixel_data = pend_vld ? pend : 24'hFFFFFF;
      pend_vld   = data_req;
      pend       = enc(int'(pixel_y), int'(pixel_x));
    end
  end

  // Entered at the negedge of frame cycle 0; leaves at the negedge of cycle ncyc.
  task automatic check_frame(input int drop_at, input int rise_at, input int fc_exp, input int ncyc);
    int h, v, de_cnt, e_de, e_req, e_rgb;
    de_cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      h     = k % 10;
      v     = k / 10;
      e_de  = (h >= 4 && h < 8 && v >= 2 && v < 5) ? 1 : 0;
      e_req = (h >= 2 && h < 6 && v >= 2 && v < 5) ? 1 : 0;
      e_rgb = (e_de != 0) ? int'(enc(v - 2, h - 4)) : 0;
      chk($sformatf("de k=%0d", k),   32'(lcd_de),      e_de);
      chk($sformatf("hs k=%0d", k),   32'(lcd_hs),      (h < 2) ? 0 : 1);
      chk($sformatf("vs k=%0d", k),   32'(lcd_vs),      (v < 1) ? 0 : 1);
      chk($sformatf("fs k=%0d", k),   32'(frame_start), (k == 0) ? 1 : 0);
      chk($sformatf("req k=%0d", k),  32'(data_req),    e_req);
      chk($sformatf("rgb k=%0d", k),  32'(lcd_rgb),     e_rgb);
      chk($sformatf("busy k=%0d", k), 32'(busy),        1);
      if (e_req != 0) begin
        chk($sformatf("px k=%0d", k), 32'(pixel_x), h - 2);
        chk($sformatf("py k=%0d", k), 32'(pixel_y), v - 2);
      end
      if (k == 0 || k == 59) chk($sformatf("fcnt k=%0d", k), 32'(frame_cnt), fc_exp);
      if (lcd_de) de_cnt++;
      if (k == drop_at) en = 1'b0;
      if (k == rise_at) en = 1'b1;
      @(negedge clk);
    end
    if (ncyc == 60) chk("de_count", de_cnt, 12);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_de",   32'(lcd_de),      0);
    chk("rst_req",  32'(data_req),    0);
    chk("rst_fs",   32'(frame_start), 0);
    chk("rst_hs",   32'(lcd_hs),      1);
    chk("rst_vs",   32'(lcd_vs),      1);
    chk("rst_rgb",  32'(lcd_rgb),     0);
    chk("rst_bl",   32'(lcd_bl),      0);
    chk("rst_fcnt", 32'(frame_cnt),   0);
    chk("rst_busy", 32'(busy),        0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("bl_on",     32'(lcd_bl), 1);
    chk("idle_busy", 32'(busy),   0);
    repeat (2) @(negedge clk);
    chk("idle_fs",   32'(frame_start), 0);
    chk("idle_hs",   32'(lcd_hs),      1);

    // Frame A: graceful stop at h=3, v=2
    en = 1'b1;
    @(negedge clk);
    check_frame(23, -1, 0, 60);
    chk("stop_busy", 32'(busy),        0);
    chk("stop_fcnt", 32'(frame_cnt),   1);
    chk("stop_fs",   32'(frame_start), 0);
    chk("stop_de",   32'(lcd_de),      0);
    chk("stop_hs",   32'(lcd_hs),      1);
    chk("stop_vs",   32'(lcd_vs),      1);
    @(negedge clk);
    chk("stop_busy2", 32'(busy), 0);

    // Frame B with STOP/resume inside it, frame C must follow with no gap
    en = 1'b1;
    @(negedge clk);
    check_frame(15, 30, 1, 60);
    check_frame(-1, -1, 2, 60);

    // Frame D: reset in the middle of active video
    check_frame(-1, -1, 3, 35);
    chk("pre_rst_de", 32'(lcd_de), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_de",   32'(lcd_de),    0);
    chk("mid_rst_hs",   32'(lcd_hs),    1);
    chk("mid_rst_vs",   32'(lcd_vs),    1);
    chk("mid_rst_fcnt", 32'(frame_cnt), 0);
    chk("mid_rst_busy", 32'(busy),      0);
    chk("mid_rst_rgb",  32'(lcd_rgb),   0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy),        0);
    chk("post_rst_fs",   32'(frame_start), 0);

    // frame_cnt wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("preload_fcnt", 32'(frame_cnt), 32'h0000FFFF);
    en = 1'b1;
    @(negedge clk);
    check_frame(50, -1, 32'h0000FFFF, 60);
    chk("wrap_fcnt", 32'(frame_cnt), 0);
    chk("wrap_busy", 32'(busy),      0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_rgb_timing.md
LCD_RGB_TIMING -- requirements
Module: lcd_rgb_timing

Interface
REQ-001 Parameter H_SYNC, default 128, horizontal sync width in pixel clocks.
REQ-002 Parameter H_BACK, default 88, horizontal back porch.
REQ-003 Parameter H_DISP, default 800, active pixels per line.
REQ-004 Parameter H_FRONT, default 40, horizontal front porch.
REQ-005 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-006 Parameter V_BACK, default 33, vertical back porch.
REQ-007 Parameter V_DISP, default 480, active lines per frame.
REQ-008 Parameter V_FRONT, default 10, vertical front porch.
REQ-009 Parameter RGB_W, default 24, pixel width; legal values are 16 and 24.
REQ-010 Parameter REQ_LEAD, default 2, request-to-display lead in clocks; legal range is 1..4, and REQ_LEAD SHALL be <= H_SYNC+H_BACK.
REQ-011 Parameter SYNC_POL, default 0, active level of lcd_hs and lcd_vs.
REQ-012 sys_clk  in  1  pixel clock; the only clock.
REQ-013 sys_rst_n  in  1  asynchronous active-low reset.
REQ-014 en  in  1  run request.
REQ-015 pixel_data  in  RGB_W  pixel value supplied by the source.
REQ-016 data_req  out  1  pixel fetch request.
REQ-017 pixel_x / pixel_y  out  11 each  coordinates of the requested pixel.
REQ-018 lcd_de / lcd_hs / lcd_vs  out  1 each  panel data enable and syncs.
REQ-019 lcd_rgb  out  RGB_W  panel pixel bus.
REQ-020 lcd_bl  out  1  backlight enable.
REQ-021 frame_start  out  1  one-clock pulse at the start of each frame.
REQ-022 frame_cnt  out  16  count of completed frames.
REQ-023 busy  out  1  high when not IDLE.

Function
REQ-024 Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
REQ-025 Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0; v_cnt increments on each h_cnt wrap and wraps to 0 after V_TOTAL-1.
REQ-026 State machine: IDLE, RUN, STOP.
- IDLE -> RUN on the clock after en is sampled high; counters start at 0.
- RUN -> STOP when en is sampled low.
- STOP -> RUN when en is sampled high; no gap and no counter reset.
- STOP -> IDLE on the wrap after h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, i.e. the current frame always completes.
REQ-027 In IDLE:
- counters are held at 0;
- lcd_de, data_req and frame_start are 0;
- lcd_hs and lcd_vs sit at the inactive level ~SYNC_POL;
- lcd_rgb is 0.
REQ-028 lcd_hs SHALL be at SYNC_POL while h_cnt < H_SYNC; lcd_vs SHALL be at SYNC_POL while v_cnt < V_SYNC; all outputs are registered.
REQ-029 lcd_de SHALL be 1 when both of these hold:
- h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP);
- v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-030 data_req SHALL assert exactly REQ_LEAD clocks before the lcd_de cycle of the same pixel; pixel_x/pixel_y SHALL give that pixel's 0-based active coordinates.
REQ-031 Requests never cross a line boundary (guaranteed by the constraint in REQ-010).
REQ-032 Data timing: pixel_data SHALL be sampled REQ_LEAD-1 clocks after data_req; lcd_rgb SHALL present the sampled value in the following clock, coincident with lcd_de.
REQ-033 lcd_rgb SHALL be 0 whenever lcd_de is 0.
REQ-034 frame_start SHALL pulse for one clock when h_cnt=0 and v_cnt=0 in RUN or STOP, including the first cycle after IDLE->RUN.
REQ-035 frame_cnt SHALL increment at each frame completion and wrap from 0xFFFF to 0.
REQ-036 lcd_bl SHALL be 1 one clock after reset release and remain 1 independent of en.

Reset
REQ-037 sys_rst_n low SHALL asynchronously force:
- state IDLE, counters 0, frame_cnt 0;
- lcd_de, data_req, frame_start, lcd_bl and lcd_rgb to 0;
- lcd_hs and lcd_vs to ~SYNC_POL.
REQ-038 A mid-frame reset SHALL abort the frame; after release, a new frame starts at count 0 only once en is sampled high.

Structure
REQ-039 A shared package lcd_timing_pkg SHALL hold:
- the state enum;
- the 800x480 default timing constants;
- a function computing H_TOTAL and V_TOTAL.
REQ-040 One sub-module, lcd_sync_cnt, SHALL implement the h/v counter pair with wrap and hold; the FSM, request, data path and outputs stay in the top module.

Verification
REQ-041 Verification parameters: H=2/2/4/2, V=1/1/3/1, REQ_LEAD=2, SYNC_POL=0.
REQ-042 Timing: en held high -> lcd_de high 4 clocks per line on lines 2..4; frame 60 clocks long; lcd_hs low at h_cnt 0..1; lcd_vs low on line 0.
REQ-043 Data path: pixel_data driven to {y,x}-encoded values 1 clock after each data_req -> lcd_rgb shows pixel (0,0) 2 clocks after the first data_req, and lcd_rgb = 0 during blanking.
REQ-044 Graceful stop: en dropped at h_cnt=3, v_cnt=2 -> frame completes, busy falls after 60th frame clock, frame_cnt = 1.
REQ-045 STOP resume: en low then high again within the same frame -> no gap; next frame_start exactly 60 clocks after the previous one.
REQ-046 Reset mid-frame: reset during active video -> lcd_de=0, lcd_hs=lcd_vs=1 immediately; frame_cnt = 0.
REQ-047 Counter wrap: frame_cnt preloaded to 0xFFFF by force -> one completed frame -> frame_cnt = 0x0000.
